// File: rtl/riscv_ram_nr1w_bypass_pkg.sv
// Shared types and helpers for the multi-read-port RAM with byte-lane bypass.
package riscv_ram_pkg;

  // Same-cycle same-address read/write policy.
  typedef enum logic {
    RDW_WRITE_FIRST,
    RDW_READ_FIRST
  } rdw_mode_e;

  // Widest word the byte-merge helper handles; callers size-cast in and out.
  localparam int MAX_DBITS = 256;
  localparam int MAX_BBITS = MAX_DBITS / 8;

  // Mode strings are carried as packed ASCII, zero-extended to this width.
  localparam int MODE_STR_BITS = 128;

  // Number of byte enables for a data width; the top lane may be partial.
  function automatic int calc_bbits(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  // True when the mode string names a supported policy.
  function automatic logic rdw_mode_ok(input logic [MODE_STR_BITS-1:0] s);
    return (s == MODE_STR_BITS'("WRITE_FIRST")) || (s == MODE_STR_BITS'("READ_FIRST"));
  endfunction

  // Map the mode string onto the enum; anything unknown is caught by rdw_mode_ok.
  function automatic rdw_mode_e rdw_mode_from_str(input logic [MODE_STR_BITS-1:0] s);
    return (s == MODE_STR_BITS'("READ_FIRST")) ? RDW_READ_FIRST : RDW_WRITE_FIRST;
  endfunction

  // Per-bit select by byte lane, so a partial top lane needs no special case.
  function automatic logic [MAX_DBITS-1:0] byte_merge(
    input logic [MAX_DBITS-1:0] old_word,
    input logic [MAX_DBITS-1:0] new_word,
    input logic [MAX_BBITS-1:0] mask
  );
    logic [MAX_DBITS-1:0] res;
    for (int i = 0; i < MAX_DBITS; i++) begin
      res[i] = mask[i / 8] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_ram_nr1w_bypass_if.sv
// Write port plus bundled read ports of the multi-read-port RAM.
interface riscv_ram_nr1w_bypass_if
  import riscv_ram_pkg::*;
#(
  parameter int ABITS  = 10,
  parameter int DBITS  = 32,
  parameter int RPORTS = 2,
  parameter int BBITS  = calc_bbits(DBITS)
);

  logic [ABITS-1:0]             waddr_i;
  logic [DBITS-1:0]             din_i;
  logic                         we_i;
  logic [BBITS-1:0]             be_i;
  logic [RPORTS-1:0][ABITS-1:0] raddr_i;
  logic [RPORTS-1:0]            re_i;
  logic [RPORTS-1:0][DBITS-1:0] dout_o;
  logic [RPORTS-1:0]            dvalid_o;

  modport master (
    output waddr_i, din_i, we_i, be_i, raddr_i, re_i,
    input  dout_o, dvalid_o
  );

  modport slave (
    input  waddr_i, din_i, we_i, be_i, raddr_i, re_i,
    output dout_o, dvalid_o
  );

endinterface

// File: rtl/riscv_ram_nr1w_bypass_rd_port.sv
// One read port: collision detect, byte-lane bypass merge, optional output
// stage and valid pipeline, sitting behind the shared array read register.
module riscv_ram_rd_port
  import riscv_ram_pkg::*;
#(
  parameter int        ABITS      = 10,
  parameter int        DBITS      = 32,
  parameter int        BBITS      = calc_bbits(DBITS),
  parameter int        RD_LATENCY = 1,
  parameter rdw_mode_e MODE       = RDW_WRITE_FIRST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [BBITS-1:0] be,
  input  logic [DBITS-1:0] din,
  input  logic [DBITS-1:0] rdata,
  output logic [DBITS-1:0] dout,
  output logic             dvalid
);

  logic [BBITS-1:0] cmask_q;
  logic [DBITS-1:0] din_q;
  logic             valid_q;
  logic [DBITS-1:0] merged;

  // Capture which lanes the same-edge write overrides, and the data to use.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmask_q <= '0;
      din_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= re;
      if (re) begin
        // READ_FIRST keeps the mask empty, so the merge returns the old word.
        cmask_q <= (MODE == RDW_WRITE_FIRST && we && raddr == waddr) ? be : '0;
        din_q   <= din;
      end
    end
  end

  // Overlay the written lanes on the array word; masked lanes never use array data.
  // NOTE: combinational outputs get a default first so no latch is inferred.
  always_comb begin
    merged = '0;
    merged = DBITS'(byte_merge(MAX_DBITS'(rdata), MAX_DBITS'(din_q), MAX_BBITS'(cmask_q)));
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DBITS-1:0] dout_q;
    logic             dvalid_q;

    // Output stage after the merge; holds the last valid word between reads.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dvalid_q <= valid_q;
        if (valid_q) dout_q <= merged;
      end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
  end else begin : g_lat1
    // Stage-1 registers only load on a read, so the merge output already holds.
    assign dout   = merged;
    assign dvalid = valid_q;
  end

endmodule

// File: rtl/riscv_ram_nr1w_bypass.sv
// Multi-read-port RAM: one byte-enabled write port, RPORTS read ports with
// per-lane read-during-write bypass and selectable 1- or 2-cycle latency.
module riscv_ram_nr1w_bypass
  import riscv_ram_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int RPORTS     = 2,
  parameter int RD_LATENCY = 1,
  parameter     RDW_MODE   = "WRITE_FIRST"
) (
  input logic clk_i,
  input logic rst_i,
  riscv_ram_nr1w_bypass_if.slave bus
);

  localparam int        DEPTH = 1 << ABITS;
  localparam int        BBITS = calc_bbits(DBITS);
  localparam rdw_mode_e MODE  = rdw_mode_from_str(MODE_STR_BITS'(RDW_MODE));

  if (RPORTS < 1 || RPORTS > 4) begin : g_bad_rports
    $error("riscv_ram_nr1w_bypass: RPORTS must be 1..4");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("riscv_ram_nr1w_bypass: RD_LATENCY must be 1 or 2");
  end
  if (!rdw_mode_ok(MODE_STR_BITS'(RDW_MODE))) begin : g_bad_mode
    $error("riscv_ram_nr1w_bypass: RDW_MODE must be WRITE_FIRST or READ_FIRST");
  end
  if (DBITS < 1 || DBITS > MAX_DBITS || ABITS < 1) begin : g_bad_width
    $error("riscv_ram_nr1w_bypass: unsupported ABITS/DBITS");
  end

  logic [DBITS-1:0] mem   [DEPTH];
  logic [DBITS-1:0] rdata [RPORTS];
  logic [DBITS-1:0] dout  [RPORTS];
  logic             dvalid[RPORTS];

  // Byte-lane write; a partial top lane covers only the remaining bits.
  // NOTE: the array has no reset so it maps onto block RAM; only control and
  // output registers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.we_i) begin
      for (int i = 0; i < DBITS; i++) begin
        if (bus.be_i[i / 8]) mem[bus.waddr_i][i] <= bus.din_i[i];
      end
    end
  end

  // One synchronous array read per port; same-edge writes are not seen here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < RPORTS; p++) rdata[p] <= '0;
    end else begin
      for (int p = 0; p < RPORTS; p++) begin
        if (bus.re_i[p]) rdata[p] <= mem[bus.raddr_i[p]];
      end
    end
  end

  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    riscv_ram_rd_port #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .BBITS      (BBITS),
      .RD_LATENCY (RD_LATENCY),
      .MODE       (MODE)
    ) u_rd_port (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .re     (bus.re_i[p]),
      .raddr  (bus.raddr_i[p]),
      .we     (bus.we_i),
      .waddr  (bus.waddr_i),
      .be     (bus.be_i),
      .din    (bus.din_i),
      .rdata  (rdata[p]),
      .dout   (dout[p]),
      .dvalid (dvalid[p])
    );
  end

  // Fan the per-port results back into the bus vectors.
  always_comb begin
    bus.dout_o   = '0;
    bus.dvalid_o = '0;
    for (int p = 0; p < RPORTS; p++) begin
      bus.dout_o[p]   = dout[p];
      bus.dvalid_o[p] = dvalid[p];
    end
  end

endmodule

// File: tb/tb_riscv_ram_nr1w_bypass.sv
// Runs four RAM configurations (latency 1/2 x WRITE_FIRST/READ_FIRST) on the
// same stimulus and compares them against a word/byte-level reference model.
module tb_riscv_ram_nr1w_bypass;

  localparam int ABITS      = 10;
  localparam int DBITS      = 32;
  localparam int RPORTS     = 2;
  localparam int NDUT       = 4;
  localparam int INIT_WORDS = 64;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         we;
  logic [ABITS-1:0]             waddr;
  logic [DBITS-1:0]             din;
  logic [3:0]                   be;
  logic [RPORTS-1:0][ABITS-1:0] raddr;
  logic [RPORTS-1:0]            re;

  logic [RPORTS-1:0][DBITS-1:0] dout_all   [NDUT];
  logic [RPORTS-1:0]            dvalid_all [NDUT];

  always #5 clk = ~clk;

  // dut 0: lat1 WRITE_FIRST, 1: lat1 READ_FIRST, 2: lat2 WRITE_FIRST, 3: lat2 READ_FIRST
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    riscv_ram_nr1w_bypass_if #(.ABITS(ABITS), .DBITS(DBITS), .RPORTS(RPORTS)) bus ();

    assign bus.waddr_i = waddr;
    assign bus.din_i   = din;
    assign bus.we_i    = we;
    assign bus.be_i    = be;
    assign bus.raddr_i = raddr;
    assign bus.re_i    = re;
    assign dout_all[g]   = bus.dout_o;
    assign dvalid_all[g] = bus.dvalid_o;

    riscv_ram_nr1w_bypass #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .RPORTS     (RPORTS),
      .RD_LATENCY ((g < 2) ? 1 : 2),
      .RDW_MODE   ((g % 2 == 1) ? "READ_FIRST" : "WRITE_FIRST")
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: plain word array, plus the outputs due at each future edge.
  logic [DBITS-1:0] mem_m   [1 << ABITS];
  bit               due_v   [NDUT][RPORTS][4];
  logic [DBITS-1:0] due_d   [NDUT][RPORTS][4];
  logic [DBITS-1:0] exp_dout[NDUT][RPORTS];
  bit               exp_vld [NDUT][RPORTS];

  function automatic int lat_of(input int d);
    return (d < 2) ? 1 : 2;
  endfunction

  function automatic bit read_first(input int d);
    return (d % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic [DBITS-1:0] obs, input logic [DBITS-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Apply the effect of one rising edge to the model, using the sampled inputs.
  task automatic model_edge();
    logic [DBITS-1:0] old_w, wf_w;
    int slot;
    cyc++;
    if (rst) begin
      for (int d = 0; d < NDUT; d++)
        for (int p = 0; p < RPORTS; p++) begin
          exp_dout[d][p] = '0;
          exp_vld[d][p]  = 1'b0;
          for (int k = 0; k < 4; k++) due_v[d][p][k] = 1'b0;
        end
    end else begin
      for (int p = 0; p < RPORTS; p++) begin
        if (re[p]) begin
          old_w = mem_m[raddr[p]];
          wf_w  = old_w;
          if (we && waddr == raddr[p])
            for (int b = 0; b < 4; b++)
              if (be[b]) wf_w[8*b +: 8] = din[8*b +: 8];
          for (int d = 0; d < NDUT; d++) begin
            slot = (cyc + lat_of(d) - 1) % 4;
            due_v[d][p][slot] = 1'b1;
            due_d[d][p][slot] = read_first(d) ? old_w : wf_w;
          end
        end
      end
      if (we)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_m[waddr][8*b +: 8] = din[8*b +: 8];
      slot = cyc % 4;
      for (int d = 0; d < NDUT; d++)
        for (int p = 0; p < RPORTS; p++) begin
          if (due_v[d][p][slot]) begin
            exp_dout[d][p] = due_d[d][p][slot];
            exp_vld[d][p]  = 1'b1;
            due_v[d][p][slot] = 1'b0;
          end else begin
            exp_vld[d][p] = 1'b0;
          end
        end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < NDUT; d++)
      for (int p = 0; p < RPORTS; p++) begin
        check($sformatf("c%0d.dut%0d.p%0d.dvalid", cyc, d, p),
              DBITS'(dvalid_all[d][p]), DBITS'(exp_vld[d][p]));
        check($sformatf("c%0d.dut%0d.p%0d.dout", cyc, d, p),
              dout_all[d][p], exp_dout[d][p]);
      end
  endtask

  // One clock: model the edge, then sample the DUTs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < NDUT; d++)
      for (int p = 0; p < RPORTS; p++) begin
        check($sformatf("%s.dut%0d.p%0d.dvalid", tag, d, p), DBITS'(dvalid_all[d][p]), '0);
        check($sformatf("%s.dut%0d.p%0d.dout", tag, d, p), dout_all[d][p], '0);
      end
  endtask

  task automatic check_direct(input string tag, input int d, input int p, input logic [DBITS-1:0] expv);
    check($sformatf("%s.dut%0d.p%0d.dvalid", tag, d, p), DBITS'(dvalid_all[d][p]), DBITS'(1));
    check($sformatf("%s.dut%0d.p%0d.dout", tag, d, p), dout_all[d][p], expv);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; din = '0; be = '0;
    raddr = '0; re = '1;

    // Reset held three cycles with every read port requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
    end
    rst = 1'b0; re = '0;
    tick();
    check_idle("post_reset");

    // Fill the working window of the array.
    we = 1'b1; be = 4'hF;
    for (int a = 0; a < INIT_WORDS; a++) begin
      waddr = ABITS'(a); din = $urandom;
      tick();
    end

    // Basic latency.
    waddr = 10'h010; din = 32'hDEADBEEF; be = 4'hF; we = 1'b1;
    tick();
    we = 1'b0; re = 2'b01; raddr[0] = 10'h010;
    tick();
    check_direct("lat_basic", 0, 0, 32'hDEADBEEF);
    check_direct("lat_basic", 1, 0, 32'hDEADBEEF);
    re = '0;
    tick();
    check_direct("lat_basic", 2, 0, 32'hDEADBEEF);
    check_direct("lat_basic", 3, 0, 32'hDEADBEEF);

    // Partial-lane collision.
    waddr = 10'h020; din = 32'h11223344; be = 4'hF; we = 1'b1;
    tick();
    din = 32'hAABBCCDD; be = 4'b0101; re = 2'b01; raddr[0] = 10'h020;
    tick();
    check_direct("coll_a", 0, 0, 32'h11BB33DD);
    check_direct("coll_a", 1, 0, 32'h11223344);
    we = 1'b0;
    tick();
    check_direct("coll_b", 0, 0, 32'h11BB33DD);
    check_direct("coll_b", 1, 0, 32'h11BB33DD);
    check_direct("coll_b", 2, 0, 32'h11BB33DD);
    check_direct("coll_b", 3, 0, 32'h11223344);
    re = '0;
    tick();
    check_direct("coll_c", 2, 0, 32'h11BB33DD);
    check_direct("coll_c", 3, 0, 32'h11BB33DD);

    // Multi-port with a full-word collision on port 1 only.
    we = 1'b1; be = 4'hF;
    waddr = 10'h030; din = 32'h30303030;
    tick();
    waddr = 10'h031; din = 32'h31313131;
    tick();
    din = 32'hCAFEF00D; re = 2'b11; raddr[0] = 10'h030; raddr[1] = 10'h031;
    tick();
    check_direct("mport", 0, 0, 32'h30303030);
    check_direct("mport", 0, 1, 32'hCAFEF00D);
    check_direct("mport", 1, 1, 32'h31313131);
    we = 1'b0; re = '0;
    tick();
    check_direct("mport", 2, 0, 32'h30303030);
    check_direct("mport", 2, 1, 32'hCAFEF00D);
    check_direct("mport", 3, 1, 32'h31313131);

    // Reset arriving while a latency-2 read is in flight.
    re = 2'b01; raddr[0] = 10'h020;
    tick();
    re = '0; rst = 1'b1;
    tick();
    check_idle("mid_reset");
    rst = 1'b0;
    tick();
    check_idle("mid_reset_after");
    re = 2'b01; raddr[0] = 10'h020;
    tick();
    check_direct("keep_mem", 0, 0, 32'h11BB33DD);
    check_direct("keep_mem", 1, 0, 32'h11BB33DD);
    re = '0;
    tick();
    check_direct("keep_mem", 2, 0, 32'h11BB33DD);
    check_direct("keep_mem", 3, 0, 32'h11BB33DD);

    // Random traffic biased towards read/write address collisions.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(49) == 0);
      we    = 1'($urandom_range(1));
      waddr = ABITS'($urandom_range(INIT_WORDS - 1));
      din   = $urandom;
      be    = 4'($urandom_range(15));
      re    = 2'($urandom_range(3));
      for (int p = 0; p < RPORTS; p++)
        raddr[p] = ($urandom_range(1) == 1) ? waddr : ABITS'($urandom_range(INIT_WORDS - 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
